regs_mp: RTL and testbench
==========================

Name: regs_mp

Overview:
Parametrised multi-port register file; successor to the 2-read/1-write CPU register file.
- Configurable width, depth and read-port count.
- Two write ports, with B having priority over A.
- Registered reads with optional same-cycle write forwarding.
- Hardware scrub after reset clears every entry before the pipeline starts issuing.
- Sits between decode (read addresses) and writeback/load-return (write ports).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = address 0 reads as 0 and writes to it are discarded; 0 = address 0 is an ordinary register

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
wa_we  in  1  write port A enable
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wb_we  in  1  write port B enable
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
init_busy  out  1  high while the post-reset scrub runs

Behaviour:
- Single clock domain (clk); rst is synchronous and active-high; all state updates on rising edge of clk.
- FSM, two states:
  - SCRUB: entered on any cycle with rst=1. Also the state on the first edge after rst deasserts.
  - RUN: entered after the last entry is cleared.
- Reset (rst=1): rd_data=0, init_busy=1, scrub counter=0, state=SCRUB. Storage is not cleared in this cycle.
- SCRUB:
  - Each cycle writes 0 to entry[counter], then increments counter.
  - When counter == 2**ADDR_W-1 is written, go to RUN.
  - Scrub takes exactly 2**ADDR_W cycles after rst deasserts; init_busy drops in the first RUN cycle.
  - Write ports are ignored.
  - rd_data is driven 0 every cycle.
  - rst during SCRUB restarts the counter at 0.
- RUN:
  - Read latency is 1 cycle: rd_data[i] at edge N+1 reflects rd_addr[i] sampled at edge N.
  - Write: entry[wx_addr] <= wx_data at the edge where wx_we=1.
  - Both ports enabled with equal address: B wins; A's write is dropped.
  - Different addresses: both commit.
  - ZERO_REG=1: address 0 always reads 0 (forwarding included); writes to address 0 are discarded.
- Forwarding (REGS_BYPASS_EN defined): a read sampled in the same cycle as an enabled write to the same address returns the write data. Priority: B data, then A data, then stored value.
- Read ports are independent; identical addresses on several ports are legal and return identical data.
- No X on rd_data after reset: every entry is defined once scrub completes.
- rst asserted mid-RUN:
  - Pending writes in that cycle are dropped.
  - rd_data goes to 0 on that edge.
  - Full scrub follows.

Optional Feature:
Macro REGS_BYPASS_EN.
- Defined: write-to-read forwarding as described under Behaviour; a value written at edge N is visible to a read sampled at edge N.
- Undefined: no forwarding; a read sampled at the edge of a same-address write returns the old stored value. The new value is visible from the next sampling edge on. This removes the address comparators, and the pipeline inserts a stall instead.

Test Plan:
1. Scrub: DATA_W=32, ADDR_W=5; rst high 2 cycles, then low -> init_busy=1 for exactly 32 cycles, then 0. Reads of addresses 0..31 all return 0x00000000.
2. Basic write/read: RUN; wa_we=1, wa_addr=5, wa_data=0xDEADBEEF; next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF one cycle later. rd_addr[1]=6 reads 0 at the same time.
3. Port conflict: wa and wb both enabled, addr=7, A=0x11111111, B=0x22222222 -> later read of 7 returns 0x22222222. With bypass on, a same-cycle read also returns 0x22222222.
4. Forwarding: wb_we=1, addr=9, data=0xCAFEF00D while rd_addr[1]=9 in the same cycle:
   - REGS_BYPASS_EN defined -> rd_data[1]=0xCAFEF00D next cycle.
   - Undefined -> the old value (0) next cycle, then 0xCAFEF00D on the following read.
5. Zero register: ZERO_REG=1; write 0xFFFFFFFF to address 0 while reading address 0 on all ports -> rd_data=0 on every port, same cycle and later.
6. Reset mid-scrub and mid-run:
   - rst pulsed when counter=10 -> init_busy stays high; scrub restarts and lasts a full 32 cycles after the pulse.
   - rst during a write of 0x12345678 to address 3 in RUN -> the write is dropped; after scrub, address 3 reads 0.

Source files
------------

// File: rtl/regs_mp_if.sv
// regs_mp_if -- bus bundle between the pipeline and the regs_mp register file.
//
// Parameters: DATA_W (data width), ADDR_W (address width), NUM_RD (read ports)
// Signals:
//   rd_addr    read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    registered read data, port i at [i*DATA_W +: DATA_W]
//   wa_we/wa_addr/wa_data   write port A (writeback)
//   wb_we/wb_addr/wb_data   write port B (load return, wins on address clash)
//   init_busy  high while the post-reset scrub runs
// Modports: master = pipeline side, slave = register file side.
interface regs_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wa_we;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_we;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     init_busy;

  modport master (
    output rd_addr, wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data,
    input  rd_data, init_busy
  );

  modport slave (
    input  rd_addr, wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data,
    output rd_data, init_busy
  );
endinterface

// File: rtl/regs_mp.sv
// regs_mp -- parametrised multi-port register file.
//
// Two write ports (B has priority over A on an address clash), NUM_RD
// registered read ports, and a hardware scrub that writes 0 to every entry
// after reset before the pipeline may issue (init_busy high meanwhile).
//
// Optional feature: define REGS_BYPASS_EN to forward same-cycle write data
// to reads of the same address (B data, then A data, then stored value).
// Without it a read returns the old stored value in the cycle of the write.
//
// Parameters: DATA_W, ADDR_W (depth = 2**ADDR_W), NUM_RD (1..4),
//             ZERO_REG (1 = address 0 reads 0 and ignores writes)
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  regs_mp_if.slave: read addresses/data, write ports A/B, init_busy
module regs_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      rst,
  regs_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_SCRUB = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [ADDR_W-1:0]  r_cnt;
  logic               w_scrub_we;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  // Effective write enables: only in RUN, and never to the hardwired zero.
  logic w_wa_ok;
  logic w_wb_ok;

  assign w_wa_ok = bus.wa_we && (r_state == S_RUN) &&
                   !((ZERO_REG != 0) && (bus.wa_addr == '0));
  assign w_wb_ok = bus.wb_we && (r_state == S_RUN) &&
                   !((ZERO_REG != 0) && (bus.wb_addr == '0));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SCRUB;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_scrub_we   = 1'b0;
    case (r_state)
      S_SCRUB: begin
        w_scrub_we = 1'b1;
        if (r_cnt == {ADDR_W{1'b1}}) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_state_next = S_RUN;
      end
      default: begin
        w_state_next = S_SCRUB;
      end
    endcase
  end

  assign bus.init_busy = (r_state == S_SCRUB);

  // Scrub pointer; wraps back to 0 after the last entry, which is harmless
  // because the FSM has left SCRUB by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_scrub_we) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  // ------------------------------------------------------------ storage
  // No reset on the array itself: the scrub defines every entry. Port B is
  // written last so it overrides port A when both hit the same entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_scrub_we) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_wa_ok) begin
          r_mem[bus.wa_addr] <= bus.wa_data;
        end
        if (w_wb_ok) begin
          r_mem[bus.wb_addr] <= bus.wb_data;
        end
      end
    end
  end

  // --------------------------------------------------------- read ports
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_val;
      logic [DATA_W-1:0] r_data;

      assign w_addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        w_val = r_mem[w_addr];
`ifdef REGS_BYPASS_EN
        // Later assignment wins: B data overrides A data.
        if (w_wa_ok && (bus.wa_addr == w_addr)) begin
          w_val = bus.wa_data;
        end
        if (w_wb_ok && (bus.wb_addr == w_addr)) begin
          w_val = bus.wb_data;
        end
`endif
        if ((ZERO_REG != 0) && (w_addr == '0)) begin
          w_val = '0;
        end
      end

      // Reads are held at 0 during reset and the whole scrub.
      always_ff @(posedge clk) begin
        if (rst || (r_state != S_RUN)) begin
          r_data <= '0;
        end else begin
          r_data <= w_val;
        end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = r_data;
    end
  endgenerate

endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp -- directed self-checking bench for regs_mp
// (DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1). Expectations that depend on
// forwarding follow REGS_BYPASS_EN.
module tb_regs_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regs_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regs_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  task automatic idle_writes();
    bus.wa_we = 1'b0;
    bus.wb_we = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 1", bus.init_busy);
    end
    n_checks++;
    if (bus.rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data);
    end
    rst = 1'b0;
    cyc = 0;
    while (bus.init_busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL scrub_length: got %0d cycles expected 32", cyc);
    end
    $display("scrub done after %0d cycles", cyc);
    for (int a = 0; a < 32; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(31 - a));
      tick();
      n_checks++;
      if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
        n_fail++;
        $display("FAIL scrub_read a=%0d: got %h/%h expected 0/0", a, rd(0), rd(1));
      end
    end
    $display("scrub readback of 32 entries done");
  endtask

  task automatic test_basic_write();
    bus.wa_we = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'hDEADBEEF;
    set_rd(0, 5'd1); set_rd(1, 5'd2);
    tick();
    idle_writes();
    set_rd(0, 5'd5); set_rd(1, 5'd6);
    tick();
    n_checks++;
    if (rd(0) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_rd0: got %h expected deadbeef", rd(0));
    end
    n_checks++;
    if (rd(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_rd1: got %h expected 0", rd(1));
    end
    $display("basic write addr5 read back %h, addr6 %h", rd(0), rd(1));
  endtask

  task automatic test_conflict();
    logic [DW-1:0] exp_same;
`ifdef REGS_BYPASS_EN
    exp_same = 32'h22222222;
`else
    exp_same = 32'h0;
`endif
    bus.wa_we = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h11111111;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h22222222;
    set_rd(0, 5'd7);
    tick();
    idle_writes();
    n_checks++;
    if (rd(0) !== exp_same) begin
      n_fail++;
      $display("FAIL conflict_same_cycle: got %h expected %h", rd(0), exp_same);
    end
    tick();
    n_checks++;
    if (rd(0) !== 32'h22222222) begin
      n_fail++;
      $display("FAIL conflict_later: got %h expected 22222222", rd(0));
    end
    $display("conflict addr7 read back %h", rd(0));
  endtask

  task automatic test_forward();
    logic [DW-1:0] exp_b;
    logic [DW-1:0] exp_a;
`ifdef REGS_BYPASS_EN
    exp_b = 32'hCAFEF00D;
    exp_a = 32'hA5A5A5A5;
`else
    exp_b = 32'h0;
    exp_a = 32'h0;
`endif
    // Port B forwarding to read port 1.
    bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hCAFEF00D;
    set_rd(0, 5'd5); set_rd(1, 5'd9);
    tick();
    idle_writes();
    n_checks++;
    if (rd(1) !== exp_b) begin
      n_fail++;
      $display("FAIL fwd_b_same: got %h expected %h", rd(1), exp_b);
    end
    n_checks++;
    if (rd(0) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL fwd_other_port: got %h expected deadbeef", rd(0));
    end
    tick();
    n_checks++;
    if (rd(1) !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL fwd_b_next: got %h expected cafef00d", rd(1));
    end
    // Port A forwarding to read port 0, port B to a different address.
    bus.wa_we = 1'b1; bus.wa_addr = 5'd10; bus.wa_data = 32'hA5A5A5A5;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd11; bus.wb_data = 32'h5A5A5A5A;
    set_rd(0, 5'd10); set_rd(1, 5'd10);
    tick();
    idle_writes();
    n_checks++;
    if (rd(0) !== exp_a || rd(1) !== exp_a) begin
      n_fail++;
      $display("FAIL fwd_a_same: got %h/%h expected %h", rd(0), rd(1), exp_a);
    end
    set_rd(0, 5'd10); set_rd(1, 5'd11);
    tick();
    n_checks++;
    if (rd(0) !== 32'hA5A5A5A5 || rd(1) !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL dual_commit: got %h/%h expected a5a5a5a5/5a5a5a5a", rd(0), rd(1));
    end
    $display("forwarding: addr9 %h addr10 %h addr11 %h", 32'hCAFEF00D, rd(0), rd(1));
  endtask

  task automatic test_zero_reg();
    bus.wa_we = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFFFFFF;
    bus.wb_we = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    set_rd(0, 5'd0); set_rd(1, 5'd0);
    tick();
    idle_writes();
    n_checks++;
    if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_same: got %h/%h expected 0/0", rd(0), rd(1));
    end
    tick();
    n_checks++;
    if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_later: got %h/%h expected 0/0", rd(0), rd(1));
    end
    $display("zero register read %h/%h", rd(0), rd(1));
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    set_rd(0, 5'd5); set_rd(1, 5'd3);
    tick();
    n_checks++;
    if (rd(0) !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pre_rst_read: got %h expected deadbeef", rd(0));
    end
    rst = 1'b1;
    bus.wa_we = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h12345678;
    tick();
    rst = 1'b0;
    idle_writes();
    n_checks++;
    if (rd(0) !== 32'h0 || bus.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run_rst: got rd0=%h busy=%b expected 0/1", rd(0), bus.init_busy);
    end
    cyc = 0;
    while (bus.init_busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL mid_run_scrub_len: got %0d expected 32", cyc);
    end
    set_rd(0, 5'd3); set_rd(1, 5'd5);
    tick();
    n_checks++;
    if (rd(0) !== 32'h0 || rd(1) !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_run_dropped: got %h/%h expected 0/0", rd(0), rd(1));
    end
    $display("reset mid-run: addr3 %h addr5 %h after %0d scrub cycles", rd(0), rd(1), cyc);
  endtask

  task automatic test_reset_mid_scrub();
    int cyc;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_scrub_busy: got %b expected 1", bus.init_busy);
    end
    cyc = 0;
    while (bus.init_busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL mid_scrub_len: got %0d expected 32", cyc);
    end
    $display("reset mid-scrub: scrub restarted, %0d cycles", cyc);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_f;
    for (int i = 0; i < 4; i++) begin
      bus.wa_we = 1'b1; bus.wa_addr = AW'(1 + i); bus.wa_data = 32'h10000000 + i;
      bus.wb_we = 1'b1; bus.wb_addr = AW'(20 + i); bus.wb_data = 32'hB0000000 + i;
      set_rd(0, AW'(1 + i)); set_rd(1, AW'(20 + i));
      tick();
`ifdef REGS_BYPASS_EN
      exp_f = 32'h10000000 + i;
`else
      exp_f = 32'h0;
`endif
      n_checks++;
      if (rd(0) !== exp_f) begin
        n_fail++;
        $display("FAIL b2b_fwd i=%0d: got %h expected %h", i, rd(0), exp_f);
      end
    end
    idle_writes();
    for (int i = 0; i < 4; i++) begin
      set_rd(0, AW'(1 + i)); set_rd(1, AW'(20 + i));
      tick();
      n_checks++;
      if (rd(0) !== 32'h10000000 + i || rd(1) !== 32'hB0000000 + i) begin
        n_fail++;
        $display("FAIL b2b_read i=%0d: got %h/%h expected %h/%h", i, rd(0), rd(1),
                 32'h10000000 + i, 32'hB0000000 + i);
      end
      $display("b2b read i=%0d: %h %h", i, rd(0), rd(1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.rd_addr = '0;
    bus.wa_we = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    test_reset();
    test_basic_write();
    test_conflict();
    test_forward();
    test_zero_reg();
    test_reset_mid_run();
    test_reset_mid_scrub();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
